mux8_arb: RTL and testbench

- Sequential controller for the 8-bit 2:1 selector (`mux8`: `s=0` passes `a`, `s=1` passes `b`).
- Arbitrates between two requesters whose data buses drive the selector's `a` and `b` inputs.
- Drives the selector's `s`, captures the selector's `y` output, and presents the captured word downstream on a valid/ready handshake.
- Round-robin fairness between sources A and B; one word in flight at a time.

---
 rtl/mux8_arb.sv | 176 +++++++++++++++++
 tb/tb_mux8_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_arb.sv
// Round-robin controller for an external 8-bit 2:1 selector: drives sel, captures y, and
// offers the captured word on a valid/ready port. Define MUX8_ARB_CNT_EN for grant counters.
module mux8_arb #(
    parameter int WIDTH     = 8,
    parameter bit FIRST_PRI = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src
`ifdef MUX8_ARB_CNT_EN
    ,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               sel_r;
    logic               sel_nxt_s;
    logic               ptr_r;
    logic               ptr_nxt_s;
    logic               gnt_a_r;
    logic               gnt_a_nxt_s;
    logic               gnt_b_r;
    logic               gnt_b_nxt_s;
    logic               valid_r;
    logic               valid_nxt_s;
    logic [WIDTH-1:0]   data_r;
    logic [WIDTH-1:0]   data_nxt_s;
    logic               src_r;
    logic               src_nxt_s;
    logic               any_req_s;

    // Pointer names the favoured source only when both sources request together.
    function automatic logic pick_src(input logic ra, input logic rb, input logic ptr);
        logic pick;
        if (ra && rb) begin
            pick = ptr;
        end else if (rb) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

    assign any_req_s = req_a | req_b;

    // Next-state and next-output decode.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        ptr_nxt_s   = ptr_r;
        gnt_a_nxt_s = 1'b0;
        gnt_b_nxt_s = 1'b0;
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        src_nxt_s   = src_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    sel_nxt_s   = pick_src(req_a, req_b, ptr_r);
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                data_nxt_s  = y_in;
                src_nxt_s   = sel_r;
                valid_nxt_s = 1'b1;
                gnt_a_nxt_s = ~sel_r;
                gnt_b_nxt_s = sel_r;
                ptr_nxt_s   = ~sel_r;
                state_nxt_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_nxt_s = 1'b0;
                    if (any_req_s) begin
                        sel_nxt_s   = pick_src(req_a, req_b, ptr_r);
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            sel_r   <= FIRST_PRI;
            ptr_r   <= FIRST_PRI;
            gnt_a_r <= 1'b0;
            gnt_b_r <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            src_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            ptr_r   <= ptr_nxt_s;
            gnt_a_r <= gnt_a_nxt_s;
            gnt_b_r <= gnt_b_nxt_s;
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
            src_r   <= src_nxt_s;
        end
    end

    assign gnt_a     = gnt_a_r;
    assign gnt_b     = gnt_b_r;
    assign sel       = sel_r;
    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_src   = src_r;

`ifdef MUX8_ARB_CNT_EN
    logic [15:0] cnt_a_r;
    logic [15:0] cnt_b_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Saturating grant counters, stepped on the edge that raises each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_r <= 16'h0000;
            cnt_b_r <= 16'h0000;
        end else begin
            if (gnt_a_nxt_s) begin
                cnt_a_r <= sat_inc(cnt_a_r);
            end
            if (gnt_b_nxt_s) begin
                cnt_b_r <= sat_inc(cnt_b_r);
            end
        end
    end

    assign cnt_a = cnt_a_r;
    assign cnt_b = cnt_b_r;
`endif

endmodule

// File: tb/tb_mux8_arb.sv
// Self-checking bench for mux8_arb: directed scenarios plus randomized traffic scored
// against a transaction-level model of round-robin arbitration and the output handshake.
module tb_mux8_arb;
    localparam int WIDTH     = 8;
    localparam bit FIRST_PRI = 1'b0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_a, req_b, gnt_a, gnt_b, sel;
    logic [WIDTH-1:0] data_a, data_b, y_in, out_data;
    logic             out_valid, out_ready, out_src;
    int               total = 0;
    int               bad   = 0;
`ifdef MUX8_ARB_CNT_EN
    logic [15:0]      cnt_a, cnt_b;
`endif

    always #5 clk = ~clk;

    // The external selector itself.
    assign y_in = sel ? data_b : data_a;

    mux8_arb #(.WIDTH(WIDTH), .FIRST_PRI(FIRST_PRI)) dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .y_in(y_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
`ifdef MUX8_ARB_CNT_EN
        , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
    );

    task automatic pulse_reset();
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
        data_a = 8'h00; data_b = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (sel !== FIRST_PRI) begin bad++; $display("FAIL reset_sel got=%0b want=%0b", sel, FIRST_PRI); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
        total++; if ({gnt_a, gnt_b} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", {gnt_a, gnt_b}); end
        total++; if (out_src !== 1'b0) begin bad++; $display("FAIL reset_src got=%0b want=0", out_src); end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || {gnt_a, gnt_b} !== 2'b00 || sel !== FIRST_PRI) begin
                bad++; $display("FAIL idle_quiet cyc=%0d valid=%0b gnt=%b sel=%0b want 0/00/%0b", i, out_valid, {gnt_a, gnt_b}, sel, FIRST_PRI);
            end
        end
    endtask

    task automatic test_single();
        req_a = 1'b1; data_a = 8'h5A; out_ready = 1'b1;
        @(negedge clk);
        total++; if (gnt_a !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_early gnt_a=%0b valid=%0b want 0/0", gnt_a, out_valid); end
        @(negedge clk);
        total++; if ({gnt_a, gnt_b} !== 2'b10) begin bad++; $display("FAIL single_gnt got=%b want=10", {gnt_a, gnt_b}); end
        total++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 1'b0) begin
            bad++; $display("FAIL single_word valid=%0b data=%h src=%0b want 1/5a/0", out_valid, out_data, out_src);
        end
        req_a = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || gnt_a !== 1'b0) begin bad++; $display("FAIL single_after valid=%0b gnt_a=%0b want 0/0", out_valid, gnt_a); end
    endtask

    task automatic test_alternation();
        pulse_reset();
        req_a = 1'b1; req_b = 1'b1; data_a = 8'h11; data_b = 8'h22; out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic       exp_v;
            logic       exp_s;
            logic [7:0] exp_d;
            @(negedge clk);
            exp_v = (k % 2 == 0);
            exp_s = ((k / 2) % 2 == 0);
            exp_d = exp_s ? 8'h22 : 8'h11;
            total++;
            if (out_valid !== exp_v) begin
                bad++; $display("FAIL alt_valid k=%0d got=%0b want=%0b", k, out_valid, exp_v);
            end else if (exp_v && (out_data !== exp_d || out_src !== exp_s || gnt_a !== ~exp_s || gnt_b !== exp_s)) begin
                bad++; $display("FAIL alt_word k=%0d data=%h src=%0b gnt=%b want %h/%0b", k, out_data, out_src, {gnt_a, gnt_b}, exp_d, exp_s);
            end
            if (k == 8) begin req_a = 1'b0; req_b = 1'b0; end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        req_b = 1'b1; data_b = 8'hC3; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (gnt_b !== 1'b1 || out_data !== 8'hC3 || out_src !== 1'b1) begin
            bad++; $display("FAIL bp_capture gnt_b=%0b data=%h src=%0b want 1/c3/1", gnt_b, out_data, out_src);
        end
        req_b = 1'b0; req_a = 1'b1; data_a = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'hC3 || {gnt_a, gnt_b} !== 2'b00) begin
                bad++; $display("FAIL bp_hold cyc=%0d valid=%0b data=%h gnt=%b want 1/c3/00", i, out_valid, out_data, {gnt_a, gnt_b});
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || gnt_a !== 1'b0) begin bad++; $display("FAIL bp_release valid=%0b gnt_a=%0b want 0/0", out_valid, gnt_a); end
        @(negedge clk);
        total++; if (gnt_a !== 1'b1 || out_data !== 8'h3C || out_src !== 1'b0) begin
            bad++; $display("FAIL bp_next gnt_a=%0b data=%h src=%0b want 1/3c/0", gnt_a, out_data, out_src);
        end
        req_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit seen;
        out_ready = 1'b0; req_a = 1'b1; data_a = 8'hA5;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gnt_a === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL areset_setup_gnt got=0 want=1"); end
        req_a = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_hold_valid got=%0b want=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== FIRST_PRI || {gnt_a, gnt_b} !== 2'b00) begin
            bad++; $display("FAIL areset_now valid=%0b data=%h sel=%0b gnt=%b want 0/00/%0b/00", out_valid, out_data, sel, {gnt_a, gnt_b}, FIRST_PRI);
        end
        @(negedge clk);
        rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1; data_a = 8'h66; data_b = 8'h99; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({gnt_a, gnt_b} !== {~FIRST_PRI, FIRST_PRI} || out_data !== (FIRST_PRI ? 8'h99 : 8'h66)) begin
            bad++; $display("FAIL areset_first gnt=%b data=%h want first source %0b", {gnt_a, gnt_b}, out_data, FIRST_PRI);
        end
        req_a = 1'b0; req_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        bit         ptr_exp, d1_a, d1_b, d2_a, d2_b, prev_valid, prev_ready, prev_src, exp_src;
        logic [7:0] prev_data;
        int         wait_a, wait_b;
        pulse_reset();
        ptr_exp = FIRST_PRI; d1_a = 0; d1_b = 0; d2_a = 0; d2_b = 0;
        prev_valid = 0; prev_ready = 0; prev_src = 0; prev_data = 8'h00; wait_a = 0; wait_b = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (prev_valid && !prev_ready) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_src !== prev_src || {gnt_a, gnt_b} !== 2'b00) begin
                    bad++; $display("FAIL rnd_stable k=%0d valid=%0b data=%h src=%0b gnt=%b want 1/%h/%0b/00", k, out_valid, out_data, out_src, {gnt_a, gnt_b}, prev_data, prev_src);
                end
            end
            if (gnt_a === 1'b1 || gnt_b === 1'b1) begin
                exp_src = (d2_a && d2_b) ? ptr_exp : d2_b;
                total++;
                if (!(d2_a || d2_b) || (gnt_a && gnt_b) || gnt_b !== exp_src) begin
                    bad++; $display("FAIL rnd_arb k=%0d gnt=%b reqs=%b ptr=%0b want src %0b", k, {gnt_a, gnt_b}, {d2_a, d2_b}, ptr_exp, exp_src);
                end
                total++;
                if (out_valid !== 1'b1 || out_src !== gnt_b || sel !== gnt_b || out_data !== (gnt_b ? data_b : data_a) || prev_valid) begin
                    bad++; $display("FAIL rnd_word k=%0d valid=%0b src=%0b sel=%0b data=%h want %h", k, out_valid, out_src, sel, out_data, gnt_b ? data_b : data_a);
                end
                ptr_exp = ~gnt_b;
            end
            wait_a = (req_a && !gnt_a) ? wait_a + 1 : 0;
            wait_b = (req_b && !gnt_b) ? wait_b + 1 : 0;
            if (wait_a > 300 || wait_b > 300) begin
                total++; bad++;
                $display("FAIL rnd_starve k=%0d wait_a=%0d wait_b=%0d want <=300", k, wait_a, wait_b);
                wait_a = 0; wait_b = 0;
            end
            d2_a = d1_a; d2_b = d1_b;
            if (gnt_a) begin req_a = ($urandom_range(1, 0) == 1); data_a = 8'($urandom); end
            else if (!req_a && $urandom_range(2, 0) == 0) begin req_a = 1'b1; data_a = 8'($urandom); end
            if (gnt_b) begin req_b = ($urandom_range(1, 0) == 1); data_b = 8'($urandom); end
            else if (!req_b && $urandom_range(2, 0) == 0) begin req_b = 1'b1; data_b = 8'($urandom); end
            out_ready  = ($urandom_range(2, 0) != 0);
            d1_a = req_a; d1_b = req_b;
            prev_valid = out_valid; prev_ready = out_ready; prev_src = out_src; prev_data = out_data;
        end
        req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

`ifdef MUX8_ARB_CNT_EN
    task automatic do_word(input bit src);
        bit seen;
        out_ready = 1'b1;
        if (src) req_b = 1'b1; else req_a = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if ((src ? gnt_b : gnt_a) === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL cnt_word_gnt src=%0b got=0 want=1", src); end
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_counters();
        pulse_reset();
        do_word(1'b0); do_word(1'b1); do_word(1'b0); do_word(1'b1); do_word(1'b0);
        total++; if (cnt_a !== 16'd3 || cnt_b !== 16'd2) begin bad++; $display("FAIL cnt_values a=%0d b=%0d want 3/2", cnt_a, cnt_b); end
        force dut.cnt_a_r = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_a_r;
        do_word(1'b0);
        total++; if (cnt_a !== 16'hFFFF) begin bad++; $display("FAIL cnt_top got=%h want=ffff", cnt_a); end
        do_word(1'b0);
        total++; if (cnt_a !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got=%h want=ffff", cnt_a); end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_alternation();
        test_backpressure();
        test_async_reset();
        test_random();
`ifdef MUX8_ARB_CNT_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
